// File: rtl/btn_debounce_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce_pkg
// Brief   : Shared state encoding and counter sizing for the button debouncer.
// Revision: 1.0 - initial release
// ============================================================================
package btn_debounce_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'b00;
  localparam state_t CONF_ON  = 2'b01;
  localparam state_t PRESSED  = 2'b10;
  localparam state_t CONF_OFF = 2'b11;

  // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_pulse_if.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce_pulse_if
// Brief   : Raw button inputs and conditioned level/pulse outputs.
// Revision: 1.0 - initial release
// ============================================================================
interface btn_debounce_pulse_if #(
  parameter int NUM_BTNS = 4
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface
`default_nettype wire

// File: rtl/btn_debounce_pulse_chan.sv
`default_nettype none
// ============================================================================
// Module  : debounce_chan
// Brief   : One button channel: 2-flop sync, debounce FSM, registered pulses.
// Revision: 1.0 - initial release
// ============================================================================
module debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_btn_raw,
  output logic      o_btn_level,
  output logic      o_btn_press,
  output logic      o_btn_release
);

  localparam int              c_CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic            r_level;
  logic            r_press;
  logic            r_release;
  logic            w_level_nxt;
  logic            w_press_nxt;
  logic            w_release_nxt;
  logic            w_cnt_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_cnt_last = (r_cnt == c_CNT_LAST);

  // State register; the level and pulse flops ride along so outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (r_sync2) begin
          w_state_nxt = CONF_ON;
          w_cnt_nxt   = '0;
        end
      end
      CONF_ON: begin
        if (!r_sync2)       w_state_nxt = IDLE;
        else if (w_cnt_last) w_state_nxt = PRESSED;
        else                 w_cnt_nxt   = r_cnt + 1'b1;
      end
      PRESSED: begin
        if (!r_sync2) begin
          w_state_nxt = CONF_OFF;
          w_cnt_nxt   = '0;
        end
      end
      CONF_OFF: begin
        if (r_sync2)         w_state_nxt = PRESSED;
        else if (w_cnt_last) w_state_nxt = IDLE;
        else                 w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Level is high whenever the confirmed state is "pressed", including its confirm-off window.
  always_comb begin
    w_level_nxt   = (w_state_nxt == PRESSED) || (w_state_nxt == CONF_OFF);
    w_press_nxt   = (r_state == CONF_ON)  &&  r_sync2 && w_cnt_last;
    w_release_nxt = (r_state == CONF_OFF) && !r_sync2 && w_cnt_last;
  end

  assign o_btn_level   = r_level;
  assign o_btn_press   = r_press;
  assign o_btn_release = r_release;

endmodule
`default_nettype wire

// File: rtl/btn_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce_pulse
// Brief   : NUM_BTNS independent debounced buttons with press/release pulses.
// Revision: 1.0 - initial release
// ============================================================================
module btn_debounce_pulse #(
  parameter int NUM_BTNS        = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input wire logic             clk,
  input wire logic             rst_n,
  btn_debounce_pulse_if.slave  bus
);

  logic [NUM_BTNS-1:0] w_level;
  logic [NUM_BTNS-1:0] w_press;
  logic [NUM_BTNS-1:0] w_release;

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
      debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_btn_raw     (bus.btn_raw[gi]),
        .o_btn_level   (w_level[gi]),
        .o_btn_press   (w_press[gi]),
        .o_btn_release (w_release[gi])
      );
    end
  endgenerate

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module  : tb_btn_debounce_pulse
// Brief   : Directed and random checks of btn_debounce_pulse against a run-length model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_btn_debounce_pulse;

  localparam int c_N = 4;
  localparam int c_D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  btn_debounce_pulse_if #(.NUM_BTNS(c_N)) bus ();

  btn_debounce_pulse #(
    .NUM_BTNS        (c_N),
    .DEBOUNCE_CYCLES (c_D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: a level flips once the synced input has disagreed with it for D+1 samples in a row.
  logic [c_N-1:0] m_s1 = '0, m_s2 = '0, m_sv = '0;
  logic [c_N-1:0] m_lvl = '0, m_prs = '0, m_rel = '0;
  int             m_run [c_N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
      for (int i = 0; i < c_N; i++) m_run[i] = 0;
    end else begin
      m_sv = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.btn_raw;
      m_prs = '0;
      m_rel = '0;
      for (int i = 0; i < c_N; i++) begin
        if (m_sv[i] != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == c_D + 1) begin
            m_lvl[i] = m_sv[i];
            if (m_sv[i]) m_prs[i] = 1'b1;
            else         m_rel[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  logic [c_N-1:0] last_press = '0;

  task automatic chk(input string tag, input logic [c_N-1:0] obs, input logic [c_N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [c_N-1:0] viol;
    @(negedge clk);
    chk("model_level",   bus.btn_level,   m_lvl);
    chk("model_press",   bus.btn_press,   m_prs);
    chk("model_release", bus.btn_release, m_rel);
    chk("pulse_overlap", bus.btn_press & bus.btn_release, '0);
    if (!rst_n) last_press = '0;
    viol = (bus.btn_press & last_press) | (bus.btn_release & ~last_press);
    chk("pulse_alternate", viol, '0);
    last_press = (last_press | bus.btn_press) & ~bus.btn_release;
  endtask

  initial begin
    bus.btn_raw = '0;
    for (int i = 0; i < c_N; i++) m_run[i] = 0;

    // 1: buttons held through reset are new presses after release
    bus.btn_raw = 4'hF;
    repeat (3) begin
      cyc();
      chk("t1_rst_level", bus.btn_level, 4'h0);
      chk("t1_rst_press", bus.btn_press, 4'h0);
    end
    rst_n = 1'b1;
    repeat (6) begin cyc(); chk("t1_no_early", bus.btn_press, 4'h0); end
    cyc(); chk("t1_press", bus.btn_press, 4'hF); chk("t1_level", bus.btn_level, 4'hF);
    cyc(); chk("t1_press_width", bus.btn_press, 4'h0); chk("t1_level_hold", bus.btn_level, 4'hF);
    bus.btn_raw = 4'h0;
    repeat (6) begin cyc(); chk("t1_no_early_rel", bus.btn_release, 4'h0); end
    cyc(); chk("t1_release", bus.btn_release, 4'hF);
    repeat (3) cyc();

    // 2: clean press on channel 0
    bus.btn_raw = 4'b0001;
    repeat (6) begin cyc(); chk("t2_no_early", bus.btn_press, 4'h0); end
    cyc(); chk("t2_press", bus.btn_press, 4'b0001); chk("t2_level", bus.btn_level, 4'b0001);
    cyc(); chk("t2_press_width", bus.btn_press, 4'h0);

    // 3: bouncing channel 1 settles high
    for (int k = 0; k < 4; k++) begin
      bus.btn_raw = (k % 2 == 0) ? 4'b0011 : 4'b0001;
      cyc(); chk("t3_bounce_quiet", bus.btn_press, 4'h0);
    end
    bus.btn_raw = 4'b0011;
    repeat (6) begin cyc(); chk("t3_no_early", bus.btn_press, 4'h0); end
    cyc(); chk("t3_press", bus.btn_press, 4'b0010);
    cyc(); chk("t3_press_width", bus.btn_press, 4'h0);

    // 4: short low glitch on a held channel 2 is ignored; a long low releases
    bus.btn_raw = 4'b0111;
    repeat (10) cyc();
    bus.btn_raw = 4'b0011;
    repeat (2) cyc();
    bus.btn_raw = 4'b0111;
    repeat (10) begin
      cyc();
      chk("t4_glitch_norel", bus.btn_release, 4'h0);
      chk("t4_glitch_level", bus.btn_level, 4'b0111);
    end
    bus.btn_raw = 4'b0011;
    repeat (6) begin cyc(); chk("t4_no_early_rel", bus.btn_release, 4'h0); end
    cyc(); chk("t4_release", bus.btn_release, 4'b0100);
    cyc(); chk("t4_level_after", bus.btn_level, 4'b0011); chk("t4_rel_width", bus.btn_release, 4'h0);
    bus.btn_raw = 4'h0;
    repeat (10) cyc();

    // 5: asynchronous reset while channel 3 is confirming and channel 0 is high
    bus.btn_raw = 4'b0001;
    repeat (10) cyc();
    bus.btn_raw = 4'b1001;
    repeat (4) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_level", bus.btn_level, 4'h0);
    chk("t5_async_press", bus.btn_press, 4'h0);
    chk("t5_async_rel",   bus.btn_release, 4'h0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (6) begin cyc(); chk("t5_no_early", bus.btn_press, 4'h0); end
    cyc(); chk("t5_press", bus.btn_press, 4'b1001); chk("t5_level", bus.btn_level, 4'b1001);

    // 6: simultaneous press on two channels
    bus.btn_raw = 4'h0;
    repeat (10) cyc();
    bus.btn_raw = 4'b1010;
    repeat (6) begin cyc(); chk("t6_no_early", bus.btn_press, 4'h0); end
    cyc(); chk("t6_press", bus.btn_press, 4'b1010);

    // Random toggling, compared against the model each cycle
    repeat (600) begin
      if ($urandom_range(0, 5) == 0)
        bus.btn_raw[$urandom_range(0, c_N - 1)] = ~bus.btn_raw[$urandom_range(0, c_N - 1)];
      if ($urandom_range(0, 9) == 0)
        bus.btn_raw = 4'($urandom_range(0, 15));
      cyc();
    end
    bus.btn_raw = 4'h0;
    repeat (12) cyc();
    chk("final_level", bus.btn_level, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
